// File: rtl/tmds_decoder_if.sv
// Signal bundle for one TMDS decoder channel: deserializer word in, decoded pixel/control out.
// With TMDS_DECODER_ERR_CNT_EN defined the bundle also carries err_count_out.
interface tmds_decoder_if;
    logic [9:0]  tmds_in;
    logic [7:0]  data_out;
    logic [1:0]  control_out;
    logic        ve_out;
    logic        locked_out;
    logic        bitslip_out;
    logic [1:0]  state_dbg;
`ifdef TMDS_DECODER_ERR_CNT_EN
    logic [15:0] err_count_out;
`endif

    // No valid/ready: one word is accepted every clock and the outputs update every clock;
    // consumers qualify the decoded stream with locked_out.
`ifdef TMDS_DECODER_ERR_CNT_EN
    modport slave  (input tmds_in, output data_out, output control_out, output ve_out,
                    output locked_out, output bitslip_out, output state_dbg, output err_count_out);
    modport master (output tmds_in, input data_out, input control_out, input ve_out,
                    input locked_out, input bitslip_out, input state_dbg, input err_count_out);
`else
    modport slave  (input tmds_in, output data_out, output control_out, output ve_out,
                    output locked_out, output bitslip_out, output state_dbg);
    modport master (output tmds_in, input data_out, input control_out, input ve_out,
                    input locked_out, input bitslip_out, input state_dbg);
`endif
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: 2-stage pixel/control decode plus control-token word-alignment FSM.
// Optional TMDS_DECODER_ERR_CNT_EN adds a saturating count of lock losses and bitslips.
module tmds_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int BITSLIP_WAIT   = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic          clk_in,
    input  logic          rst_in,
    tmds_decoder_if.slave bus
);
    localparam int TMAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
    localparam int TW   = (TMAX > BITSLIP_WAIT) ? $clog2(TMAX) : $clog2(BITSLIP_WAIT + 1);
    localparam int RW   = $clog2(CTRL_RUN + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, SLIP_WAIT = 2'd1, LOCKED = 2'd2} state_t;

    logic [9:0]    tmds_q;
    logic          tok_q, tok_d, vld_q;
    logic [1:0]    tokv_q, tokv_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          ve_q, ve_d;
    logic [RW-1:0] run_q, run_d;
    logic [TW-1:0] timer_q;
    state_t        state_q;
    logic          locked_q, bitslip_q;
    logic          qualify, slip_fire, lock_loss;

    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        d    = w[9] ? ~w[7:0] : w[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    always_comb begin
        tok_d  = 1'b1;
        tokv_d = 2'b00;
        case (bus.tmds_in)
            10'b1101010100: tokv_d = 2'b00;
            10'b0010101011: tokv_d = 2'b01;
            10'b0101010100: tokv_d = 2'b10;
            10'b1010101011: tokv_d = 2'b11;
            default:        tok_d  = 1'b0;
        endcase
    end

    // vld_q keeps the reset contents of stage 1 from being decoded as a data word.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        ve_d   = ve_q;
        if (vld_q) begin
            if (tok_q) begin
                ve_d   = 1'b0;
                ctrl_d = tokv_q;
            end else begin
                ve_d   = 1'b1;
                data_d = decode(tmds_q);
            end
        end
    end

    always_comb begin
        run_d = run_q;
        if (state_q == SLIP_WAIT || !tok_q) run_d = '0;
        else if (run_q != RW'(CTRL_RUN))   run_d = run_q + 1'b1;
    end

    assign qualify   = tok_q && (state_q != SLIP_WAIT) && (run_q == RW'(CTRL_RUN - 1));
    assign slip_fire = (state_q == SEARCH) && !qualify && (timer_q == TW'(SEARCH_TIMEOUT - 1));
    assign lock_loss = (state_q == LOCKED) && !qualify && (timer_q == TW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tmds_q <= '0;
            tok_q  <= 1'b0;
            tokv_q <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            ctrl_q <= '0;
            ve_q   <= 1'b0;
            run_q  <= '0;
        end else begin
            tmds_q <= bus.tmds_in;
            tok_q  <= tok_d;
            tokv_q <= tokv_d;
            vld_q  <= 1'b1;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            ve_q   <= ve_d;
            run_q  <= run_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= SEARCH;
            timer_q   <= '0;
            locked_q  <= 1'b0;
            bitslip_q <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (qualify) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        timer_q  <= '0;
                    end else if (slip_fire) begin
                        state_q   <= SLIP_WAIT;
                        bitslip_q <= 1'b1;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                // The pulse cycle itself is timer 0, so BITSLIP_WAIT quiet cycles follow it.
                SLIP_WAIT: begin
                    if (timer_q == TW'(BITSLIP_WAIT)) begin
                        state_q <= SEARCH;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (qualify) begin
                        timer_q <= '0;
                    end else if (lock_loss) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                    timer_q  <= '0;
                end
            endcase
        end
    end

`ifdef TMDS_DECODER_ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                                      err_q <= '0;
        else if ((slip_fire || lock_loss) && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end

    assign bus.err_count_out = err_q;
`endif

    assign bus.data_out    = data_q;
    assign bus.control_out = ctrl_q;
    assign bus.ve_out      = ve_q;
    assign bus.locked_out  = locked_q;
    assign bus.bitslip_out = bitslip_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: scoreboarded decode pipeline, lock acquire/loss, bitslip cadence.
module tb_tmds_decoder;
    localparam int CR = 8;
    localparam int ST = 64;
    localparam int BW = 4;
    localparam int LT = 64;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    tmds_decoder_if bus();

    tmds_decoder #(
        .CTRL_RUN(CR), .SEARCH_TIMEOUT(ST), .BITSLIP_WAIT(BW), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  m_data;
    logic [1:0]  m_ctrl;
    logic        prev_slip;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        d = w[7:0] ^ {8{w[9]}};
        o = d ^ {d[6:0], 1'b0};
        if (!w[8]) o = o ^ 8'hFE;
        return o;
    endfunction

    // {is_token, value}
    function automatic logic [2:0] model_tok(input logic [9:0] w);
        case (w)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        while (model_tok(w)[2]) w = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    task automatic push(input logic [9:0] w);
        logic [2:0] t;
        t = model_tok(w);
        if (t[2]) m_ctrl = t[1:0];
        else      m_data = model_decode(w);
        exp_q.push_back({~t[2], m_ctrl, m_data});
    endtask

    // Called at a negedge: drive a word, clock it, then score the word from one step earlier.
    task automatic step(input logic [9:0] w);
        logic [10:0] e;
        bus.tmds_in = w;
        push(w);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk("ve_out",      16'(bus.ve_out),      16'(e[10]));
            chk("control_out", 16'(bus.control_out), 16'(e[9:8]));
            chk("data_out",    16'(bus.data_out),    16'(e[7:0]));
        end
        if (prev_slip) chk("bitslip_back_to_back", 16'(bus.bitslip_out), 16'd0);
        prev_slip = bus.bitslip_out;
    endtask

    // Called at a negedge: asynchronous assert between edges, one cycle low, release at a negedge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data",    16'(bus.data_out),    16'd0);
        chk("rst_control", 16'(bus.control_out), 16'd0);
        chk("rst_ve",      16'(bus.ve_out),      16'd0);
        chk("rst_locked",  16'(bus.locked_out),  16'd0);
        chk("rst_bitslip", 16'(bus.bitslip_out), 16'd0);
        chk("rst_state",   16'(bus.state_dbg),   16'd0);
`ifdef TMDS_DECODER_ERR_CNT_EN
        chk("rst_err_count", bus.err_count_out, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        exp_q.delete();
        m_data = 8'h00;
        m_ctrl = 2'b00;
        prev_slip = 1'b0;
    endtask

    initial begin
        bus.tmds_in = 10'd0;
        apply_reset();

        // Lock on a run of blanking tokens; the 8th token is sampled at cycle 8.
        for (int i = 0; i < 20; i++) begin
            step(TOK0);
            chk("lock_acquire", 16'(bus.locked_out), 16'(cyc >= 9));
            chk("no_slip_acq",  16'(bus.bitslip_out), 16'd0);
        end
        chk("state_locked", 16'(bus.state_dbg), 16'd2);

        // Data words while locked, including the two hand-picked extremes.
        step(10'b0100000000);
        step(10'b1100000000);
        for (int i = 0; i < 6; i++) step(rand_data());
        for (int i = 0; i < 3; i++) begin
            step(TOK1);
            step(TOK3);
        end
        step(rand_data());
        chk("still_locked", 16'(bus.locked_out), 16'd1);

        // Mid-run reset while locked, then relock and let the lock time out.
        apply_reset();
        for (int i = 0; i < 8; i++) step(TOK0);
        step(rand_data());
        for (int i = 0; i < 2; i++) begin
            step(TOK1);
            step(TOK3);
        end
        step(rand_data());
        for (int i = 0; i < 4; i++) step(TOK3);
        while (cyc < 80) begin
            step(rand_data());
            chk("lock_timeout", 16'(bus.locked_out), 16'(cyc >= 9 && cyc < 73));
            chk("no_slip_lock", 16'(bus.bitslip_out), 16'd0);
        end
`ifdef TMDS_DECODER_ERR_CNT_EN
        chk("err_after_loss", bus.err_count_out, 16'd1);
`endif

        // No tokens at all: periodic bitslip with period ST + BW + 1.
        apply_reset();
        while (cyc < 210) begin
            step(rand_data());
            chk("bitslip_cadence", 16'(bus.bitslip_out), 16'(cyc == 64 || cyc == 133 || cyc == 202));
            chk("never_locked",    16'(bus.locked_out),  16'd0);
        end
`ifdef TMDS_DECODER_ERR_CNT_EN
        chk("err_after_slips", bus.err_count_out, 16'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
